// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, function encodings and the legal-encoding check.
// Used by the ALU share arbiter and its round-robin sub-block.
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [3:0] FN_AND  = 4'b0000;
   localparam logic [3:0] FN_OR   = 4'b0001;
   localparam logic [3:0] FN_XOR  = 4'b0010;
   localparam logic [3:0] FN_XNOR = 4'b0011;
   localparam logic [3:0] FN_ADD  = 4'b0100;
   localparam logic [3:0] FN_SUB  = 4'b1100;
   localparam logic [3:0] FN_SLT  = 4'b1101;
   localparam logic [3:0] FN_SLTU = 4'b0110;

   function automatic logic func_legal(input logic [3:0] func);
      case (func)
         FN_AND, FN_OR, FN_XOR, FN_XNOR,
         FN_ADD, FN_SUB, FN_SLT, FN_SLTU: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention the
// priority pointer picks, and it moves to the other slot after every grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       prio
);

   logic prio_q;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= 1'b0;
      end else if (|gnt) begin
         // Granting slot 0 hands priority to slot 1 and vice versa.
         prio_q <= gnt[0];
      end
   end

   assign prio = prio_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two issue slots and registers the result toward writeback.
// Optional per-slot grant and stall counters are built when ALU_SHARE_PERF_EN is defined.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [3:0]       req_func0,
   input  logic [3:0]       req_func1,
   input  logic [TAG_W-1:0] req_tag0,
   input  logic [TAG_W-1:0] req_tag1,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [3:0]       alu_func,
   input  logic [WIDTH-1:0] alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_src,
   output logic             res_err
`ifdef ALU_SHARE_PERF_EN
   ,
   output logic [31:0]      perf_grant0,
   output logic [31:0]      perf_grant1,
   output logic [31:0]      perf_stall
`endif
);

   logic       can_issue;
   logic [1:0] gnt;
   logic       prio;
   logic       sel;
   logic       xfer;
   logic       legal;

   assign can_issue = !res_valid || res_ready;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req_valid),
      .en    (can_issue && !reset),
      .gnt   (gnt),
      .prio  (prio)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   // Without a grant the ALU still sees a real slot (the priority one), never X.
   assign sel      = xfer ? gnt[1] : prio;
   assign alu_in1  = sel ? req_a1    : req_a0;
   assign alu_in2  = sel ? req_b1    : req_b0;
   assign alu_func = sel ? req_func1 : req_func0;
   assign legal    = func_legal(alu_func);

   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
         res_src   <= 1'b0;
         res_err   <= 1'b0;
      end else if (xfer) begin
         res_valid <= 1'b1;
         res_data  <= legal ? alu_out : '0;
         res_tag   <= sel ? req_tag1 : req_tag0;
         res_src   <= sel;
         res_err   <= !legal;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

`ifdef ALU_SHARE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_grant0 <= '0;
         perf_grant1 <= '0;
         perf_stall  <= '0;
      end else begin
         if (gnt[0]) perf_grant0 <= perf_grant0 + 32'd1;
         if (gnt[1]) perf_grant1 <= perf_grant1 + 32'd1;
         if ((|req_valid) && !xfer) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
